ppu_oam_dma: RTL and testbench

PPU_OAM_DMA -- requirements
Module: ppu_oam_dma

---
 rtl/ppu_pkg.sv | 15 +
 rtl/ppu_oam_dma.sv | 76 +++++++
 tb/tb_ppu_oam_dma.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: OAM DMA state encoding and transfer length.
// Imported by the OAM DMA engine and its bench.
package ppu_pkg;

    localparam int OAM_DMA_LEN = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } dma_state_t;

endpackage

// File: rtl/ppu_oam_dma.sv
// OAM DMA engine: a CPU write to $4014 stalls the CPU and copies one
// 256-byte page from the CPU bus into OAMDATA, one byte per read/write pair.
// Ports:
//   clk, rst             CPU-rate clock, async active-high reset
//   dma_write_en/page_in request pulse and source page (high byte)
//   cpu_halt             stall request to the CPU while busy
//   cpu_read_en/addr_out bus read strobe and address
//   cpu_data_in          read data, valid the cycle after the read
//   oamdata_write_en/in  write strobe and byte to OAMDATA
//   dma_busy, dma_done   busy flag, pulse on the last OAM write
module ppu_oam_dma
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_write_en,
    input  logic [7:0]  dma_page_in,
    output logic        cpu_halt,
    output logic        cpu_read_en,
    output logic [15:0] cpu_addr_out,
    input  logic [7:0]  cpu_data_in,
    output logic        oamdata_write_en,
    output logic [7:0]  oamdata_in,
    output logic        dma_busy,
    output logic        dma_done
);

    localparam logic [7:0] LAST_BYTE = 8'(OAM_DMA_LEN - 1);

    dma_state_t state, state_nx;
    logic       parity;
    logic [7:0] page;
    logic [7:0] count;

    // Parity free-runs from reset so the get/put phase tracks the CPU
    // cycle even while idle; it decides whether HALT needs an ALIGN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            parity <= 1'b0;
            page   <= 8'h00;
            count  <= 8'h00;
        end else begin
            state  <= state_nx;
            parity <= ~parity;
            if (state == ST_IDLE && dma_write_en) begin
                page  <= dma_page_in;
                count <= 8'h00;
            end else if (state == ST_WRITE) begin
                // 8-bit wrap keeps the address inside the source page
                count <= count + 8'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (dma_write_en) state_nx = ST_HALT;
            ST_HALT:  state_nx = parity ? ST_READ : ST_ALIGN;
            ST_ALIGN: state_nx = ST_READ;
            ST_READ:  state_nx = ST_WRITE;
            ST_WRITE: state_nx = (count == LAST_BYTE) ? ST_IDLE : ST_READ;
            default:  state_nx = ST_IDLE;
        endcase
    end

    assign dma_busy         = (state != ST_IDLE);
    assign cpu_halt         = dma_busy;
    assign cpu_read_en      = (state == ST_READ);
    assign cpu_addr_out     = cpu_read_en ? {page, count} : 16'h0000;
    assign oamdata_write_en = (state == ST_WRITE);
    assign oamdata_in       = oamdata_write_en ? cpu_data_in : 8'h00;
    assign dma_done         = oamdata_write_en && (count == LAST_BYTE);

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Directed bench for ppu_oam_dma: full transfers with and without ALIGN,
// ignored requests, reset abort, top-page transfer.
module tb_ppu_oam_dma;
    import ppu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_write_en;
    logic [7:0]  dma_page_in;
    logic        cpu_halt;
    logic        cpu_read_en;
    logic [15:0] cpu_addr_out;
    logic [7:0]  cpu_data_in;
    logic        oamdata_write_en;
    logic [7:0]  oamdata_in;
    logic        dma_busy;
    logic        dma_done;

    int checks = 0;
    int passed = 0;
    int unsigned edges;

    ppu_oam_dma dut (
        .clk              (clk),
        .rst              (rst),
        .dma_write_en     (dma_write_en),
        .dma_page_in      (dma_page_in),
        .cpu_halt         (cpu_halt),
        .cpu_read_en      (cpu_read_en),
        .cpu_addr_out     (cpu_addr_out),
        .cpu_data_in      (cpu_data_in),
        .oamdata_write_en (oamdata_write_en),
        .oamdata_in       (oamdata_in),
        .dma_busy         (dma_busy),
        .dma_done         (dma_done)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; edge N sees DUT parity N%2.
    always @(posedge clk or posedge rst)
        if (rst) edges <= 0;
        else     edges <= edges + 1;

    function automatic logic [7:0] mem_val(input logic [15:0] a);
        return 8'(a[7:0] * 8'd7 + a[15:8]) ^ 8'h3C;
    endfunction

    // Bus memory: data returns the cycle after the read strobe.
    always @(posedge clk)
        cpu_data_in <= cpu_read_en ? mem_val(cpu_addr_out) : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] out_vec();
        return {cpu_halt, cpu_read_en, cpu_addr_out, oamdata_write_en,
                oamdata_in, dma_busy, dma_done};
    endfunction

    // One transfer, sampled at every falling edge.
    // align: arrange HALT at parity 0 so one ALIGN cycle is expected.
    // inject_at: fire a page-0x07 request after that many writes.
    // abort_at: assert rst once that many writes are done.
    // late: pulse dma_write_en during the final WRITE cycle.
    task automatic run(input logic [7:0] page, input bit align,
                       input int inject_at, input int abort_at,
                       input bit late);
        int  busy_cyc = 0;
        int  rd = 0;
        int  wr = 0;
        int  dones = 0;
        int  nonrw = 0;
        bit  prev_rd = 0;
        bit  prev_done = 0;
        logic [15:0] a;
        if ((edges % 2 == 0) == align) @(negedge clk);
        dma_page_in  = page;
        dma_write_en = 1'b1;
        @(negedge clk);
        dma_write_en = 1'b0;
        for (int g = 0; g < 600; g++) begin
            if (!dma_busy) break;
            busy_cyc++;
            dma_write_en = 1'b0;
            chk("halt_eq_busy", cpu_halt, dma_busy);
            if (oamdata_write_en) chk("wr_after_rd", prev_rd, 1);
            if (cpu_read_en) begin
                a = {page, 8'(rd)};
                chk("rd_addr", cpu_addr_out, a);
                rd++;
            end
            if (oamdata_write_en) begin
                a = {page, 8'(wr)};
                chk("wr_data", oamdata_in, mem_val(a));
                wr++;
            end
            if (!cpu_read_en && !oamdata_write_en) nonrw++;
            if (dma_done) begin
                dones++;
                chk("done_on_last", wr, 256);
                if (late) begin
                    dma_page_in  = 8'h55;
                    dma_write_en = 1'b1;
                end
            end
            if (inject_at >= 0 && wr == inject_at && oamdata_write_en) begin
                dma_page_in  = 8'h07;
                dma_write_en = 1'b1;
            end
            prev_rd   = cpu_read_en;
            prev_done = dma_done;
            if (abort_at >= 0 && wr == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_outs_zero", out_vec(), 0);
                chk("abort_no_done", dones, 0);
                return;
            end
            @(negedge clk);
        end
        dma_write_en = 1'b0;
        chk("busy_cycles", busy_cyc, align ? 514 : 513);
        chk("halt_align_cycles", nonrw, align ? 2 : 1);
        chk("read_count", rd, 256);
        chk("write_count", wr, 256);
        chk("done_count", dones, 1);
        chk("busy_drop_after_done", prev_done, 1);
        chk("idle_outs_zero", out_vec(), 0);
        @(negedge clk);
        chk("stays_idle", dma_busy, 0);
    endtask

    initial begin
        rst          = 1'b1;
        dma_write_en = 1'b0;
        dma_page_in  = 8'h00;
        @(negedge clk);
        chk("reset_outs_zero", out_vec(), 0);
        @(negedge clk);
        rst = 1'b0;
        run(8'h02, 1'b0, -1, -1, 1'b0);
        run(8'h02, 1'b1, -1, -1, 1'b0);
        run(8'h02, 1'b0, 40, -1, 1'b0);
        run(8'h02, 1'b0, -1, 101, 1'b0);
        @(negedge clk);
        chk("held_reset_idle", out_vec(), 0);
        rst = 1'b0;
        run(8'h03, 1'b0, -1, -1, 1'b0);
        run(8'hFF, 1'b1, -1, -1, 1'b1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
